i2c_bit_engine: RTL
===================

// Module: i2c_bit_engine
// PURPOSE
//  Byte/bit-level I2C master sequencer. Sits directly downstream of the system clock divider.
//  - Consumes a quarter-bit strobe (tick_i, 4 ticks per SCL period).
//  - Executes one command at a time: START, WRITE, READ or STOP.
//  - Drives SCL/SDA as open-drain enables; returns data/ACK per command.
//  - Feeds the AXI-Stream I2C master FSM above it.
// PARAMETERS
//  SYNC_STAGES     2     flops on scl_i/sda_i synchronizers (>=2)
//  STRETCH_TIMEOUT 1024  max ticks to wait for SCL high (only with I2C_CLK_STRETCH_EN)
// PORTS
//  clk_i        in   1  system clock
//  arstn_i      in   1  async active-low reset
//  tick_i       in   1  quarter-bit strobe, 1-cycle pulse, from divider
//  cmd_valid_i  in   1  command valid
//  cmd_ready_o  out  1  engine idle, command accepted on valid&ready
//  cmd_i        in   2  00 START (incl. repeated), 01 WRITE, 10 READ, 11 STOP
//  cmd_data_i   in   8  WRITE byte, sent MSB first
//  cmd_ack_i    in   1  READ: master ACK bit (0=ACK, 1=NACK)
//  rsp_valid_o  out  1  1-cycle pulse on command completion, no backpressure
//  rsp_data_o   out  8  READ byte (MSB first received); holds until next READ
//  rsp_ack_o    out  1  WRITE: sampled slave ACK; READ: echo of cmd_ack_i; START/STOP: 0
//  rsp_err_o    out  1  stretch timeout (0 without macro)
//  busy_o       out  1  command in progress
//  scl_i/sda_i  in   1  bus line readback (async, synchronized internally)
//  scl_oe_o     out  1  1 = pull SCL low, 0 = release
//  sda_oe_o     out  1  1 = pull SDA low, 0 = release
// BEHAVIOUR
//  Clock: single clock clk_i; reset arstn_i is asynchronous, active-low.
//  Reset values:
//  - scl_oe_o = sda_oe_o = 0 (bus released).
//  - rsp_* = 0, busy_o = 0, cmd_ready_o = 1.
//  - Reset mid-command aborts immediately, with no STOP issued.
//  FSM states:
//  - IDLE -> START | BIT | STOP on accept.
//  - START, STOP -> DONE.
//  - BIT, 9 bits -> DONE.
//  - DONE -> IDLE, after 1 cycle with rsp_valid_o = 1.
//  Handshake:
//  - cmd_ready_o = 1 only in IDLE.
//  - busy_o = 1 from the cycle after accept until the rsp_valid_o cycle inclusive.
//  - cmd fields are registered at accept.
//  Phases: phase counter p = 0..3 advances only on tick_i; transition p3 -> exit happens on a tick.
//  START:
//  - p0: SDA released, SCL unchanged.
//  - p1: SCL released.
//  - p2: SDA low.
//  - p3: SCL low.
//  - Exit leaves SCL low, SDA low.
//  STOP:
//  - p0: SCL low, SDA low.
//  - p1: SCL released.
//  - p2: SDA released.
//  - p3: hold.
//  - Exit leaves bus released.
//  BIT n (n = 0..8):
//  - p0-p1: SCL low, SDA set.
//  - p2-p3: SCL released.
//  - SDA is sampled (synced value) on the tick ending p2.
//  - SDA value for WRITE: bits 0..7 from cmd_data_i MSB first; bit 8 released, sampled into rsp_ack_o.
//  - SDA value for READ: bits 0..7 released, sampled into rsp_data_o; bit 8 driven to cmd_ack_i.
//  - Bit 8 exit (tick ending p3) drives SCL low; lines hold between commands.
//  Latency (ticks every cycle): START/STOP rsp_valid_o 5 cycles after accept; WRITE/READ 37.
//  Commands need no prior START; the bus is driven exactly as specified regardless.
//  tick_i in IDLE is ignored. tick_i held high advances one phase per cycle.
//  cmd_valid_i during busy is not accepted; it must be held (AXIS rules).
// CONFIGURATION
//  I2C_CLK_STRETCH_EN defined:
//  - In p2 of any START/STOP/BIT, the phase advances only on a tick while synced scl_i == 1.
//  - Ticks seen with scl_i == 0 are counted.
//  - At STRETCH_TIMEOUT: release both lines, jump to DONE, rsp_err_o = 1 with rsp_valid_o.
//  I2C_CLK_STRETCH_EN undefined:
//  - scl_i is unused; timing is purely tick-driven; rsp_err_o is tied 0.
// TESTING
//  1. Reset with tick_i = 1 each cycle, START:
//     - rsp_valid_o 5 cycles later.
//     - sda_oe_o rises before scl_oe_o, giving a legal start edge.
//  2. WRITE 0xA5, slave model ACKs (sda_i = 0 in bit 8):
//     - SDA pattern 1,0,1,0,0,1,0,1 observed at SCL rising.
//     - rsp_ack_o = 0.
//  3. WRITE 0x3C, no slave (sda_i pulled 1):
//     - rsp_ack_o = 1; rsp_valid_o single pulse.
//  4. READ, slave returns 0x96, cmd_ack_i = 1:
//     - rsp_data_o = 0x96, rsp_ack_o = 1.
//     - Bit 8 SDA released.
//  5. STOP after READ:
//     - SCL released before SDA release.
//     - Final scl_oe_o = sda_oe_o = 0; cmd_ready_o = 1.
//  6. Reset asserted at bit 4 of a WRITE:
//     - Both oe drop the same cycle.
//     - Next command after release starts at p0.
//  6a. With I2C_CLK_STRETCH_EN, STRETCH_TIMEOUT = 16, hold scl_i = 0:
//     - Stalls in p2.
//     - After 16 ticks, rsp_err_o = 1 and both lines released.

Source files
------------

// File: rtl/i2c_bit_engine_if.sv
// Command/response bundle between the I2C byte-level FSM and the bit engine.
// master = command issuer, slave = bit engine.
interface i2c_bit_engine_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [1:0] cmd_i;
    logic [7:0] cmd_data_i;
    logic       cmd_ack_i;
    logic       rsp_valid_o;
    logic [7:0] rsp_data_o;
    logic       rsp_ack_o;
    logic       rsp_err_o;

    modport master (
        output cmd_valid_i, cmd_i, cmd_data_i, cmd_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_ack_o, rsp_err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_i, cmd_data_i, cmd_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_ack_o, rsp_err_o
    );
endinterface

// File: rtl/i2c_bit_engine.sv
// I2C master bit sequencer: START/WRITE/READ/STOP on quarter-bit ticks.
// Optional clock stretching with timeout: define I2C_CLK_STRETCH_EN.
module i2c_bit_engine #(
    parameter int SYNC_STAGES     = 2,
    parameter int STRETCH_TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              tick_i,
    i2c_bit_engine_if.slave   bus,
    output logic              busy_o,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              scl_oe_o,
    output logic              sda_oe_o
);
    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_READ  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_STOP, S_DONE
    } state_t;

    state_t     state_q, state_n;
    logic [1:0] phase_q, phase_n;
    logic [3:0] bit_q, bit_n;
    logic [1:0] cmd_q, cmd_n;
    logic [7:0] data_q, data_n;
    logic       ack_q, ack_n;
    logic [7:0] shr_q, shr_n;
    logic       asmp_q, asmp_n;
    logic       scl_q, scl_n;
    logic       sda_q, sda_n;
    logic [7:0] rdata_q, rdata_n;
    logic       rack_q, rack_n;
    logic       rerr_q, rerr_n;
    logic       adv;

    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   sda_s;

    // SDA readback synchronizer; idle bus reads high
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) sda_sync <= '1;
        else          sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
    end
    assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_CLK_STRETCH_EN
    localparam int CW = $clog2(STRETCH_TIMEOUT + 1);
    logic [SYNC_STAGES-1:0] scl_sync;
    logic                   scl_s;
    logic [CW-1:0]          st_cnt_q, st_cnt_n;

    // SCL readback synchronizer and stretch tick counter
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            scl_sync <= '1;
            st_cnt_q <= '0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            st_cnt_q <= st_cnt_n;
        end
    end
    assign scl_s = scl_sync[SYNC_STAGES-1];
`else
    logic unused_scl;
    assign unused_scl = scl_i;
`endif

    // SDA pull-down for bit n of a WRITE/READ (1 = drive low)
    function automatic logic bit_drive(input logic [1:0] c,
                                       input logic [7:0] d,
                                       input logic       a,
                                       input logic [3:0] n);
        logic [2:0] i;
        i = 3'(4'd7 - n);
        if (n == 4'd8) return (c == C_READ) ? ~a : 1'b0;
        return (c == C_WRITE) ? ~d[i] : 1'b0;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            shr_q   <= '0;
            asmp_q  <= 1'b0;
            scl_q   <= 1'b0;
            sda_q   <= 1'b0;
            rdata_q <= '0;
            rack_q  <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            phase_q <= phase_n;
            bit_q   <= bit_n;
            cmd_q   <= cmd_n;
            data_q  <= data_n;
            ack_q   <= ack_n;
            shr_q   <= shr_n;
            asmp_q  <= asmp_n;
            scl_q   <= scl_n;
            sda_q   <= sda_n;
            rdata_q <= rdata_n;
            rack_q  <= rack_n;
            rerr_q  <= rerr_n;
        end
    end

    // Next state, line drive on phase entry, bit sampling and response
    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        bit_n   = bit_q;
        cmd_n   = cmd_q;
        data_n  = data_q;
        ack_n   = ack_q;
        shr_n   = shr_q;
        asmp_n  = asmp_q;
        scl_n   = scl_q;
        sda_n   = sda_q;
        rdata_n = rdata_q;
        rack_n  = rack_q;
        rerr_n  = rerr_q;
        adv     = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
        st_cnt_n = st_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    cmd_n   = bus.cmd_i;
                    data_n  = bus.cmd_data_i;
                    ack_n   = bus.cmd_ack_i;
                    phase_n = '0;
                    bit_n   = '0;
                    unique case (bus.cmd_i)
                        C_START: begin
                            state_n = S_START;
                            sda_n   = 1'b0;
                        end
                        C_WRITE, C_READ: begin
                            state_n = S_BIT;
                            scl_n   = 1'b1;
                            sda_n   = bit_drive(bus.cmd_i, bus.cmd_data_i,
                                                bus.cmd_ack_i, 4'd0);
                        end
                        default: begin
                            state_n = S_STOP;
                            scl_n   = 1'b1;
                            sda_n   = 1'b1;
                        end
                    endcase
                end
            end
            S_START, S_BIT, S_STOP: begin
                adv = tick_i;
`ifdef I2C_CLK_STRETCH_EN
                if (phase_q == 2'd2 && !scl_s) begin
                    adv = 1'b0;
                    if (tick_i) begin
                        if (st_cnt_q == CW'(STRETCH_TIMEOUT - 1)) begin
                            state_n  = S_DONE;
                            scl_n    = 1'b0;
                            sda_n    = 1'b0;
                            rack_n   = 1'b0;
                            rerr_n   = 1'b1;
                            st_cnt_n = '0;
                        end else begin
                            st_cnt_n = st_cnt_q + 1'b1;
                        end
                    end
                end
                if (adv) st_cnt_n = '0;
`endif
                if (adv) begin
                    phase_n = phase_q + 2'd1;
                    if (state_q == S_START) begin
                        unique case (phase_q)
                            2'd0: scl_n = 1'b0;
                            2'd1: sda_n = 1'b1;
                            2'd2: scl_n = 1'b1;
                            default: begin
                                state_n = S_DONE;
                                rack_n  = 1'b0;
                                rerr_n  = 1'b0;
                            end
                        endcase
                    end else if (state_q == S_STOP) begin
                        unique case (phase_q)
                            2'd0: scl_n = 1'b0;
                            2'd1: sda_n = 1'b0;
                            2'd2: ;
                            default: begin
                                state_n = S_DONE;
                                rack_n  = 1'b0;
                                rerr_n  = 1'b0;
                            end
                        endcase
                    end else begin
                        unique case (phase_q)
                            2'd0: ;
                            2'd1: scl_n = 1'b0;
                            2'd2: begin
                                if (bit_q == 4'd8) asmp_n = sda_s;
                                else shr_n = {shr_q[6:0], sda_s};
                            end
                            default: begin
                                scl_n = 1'b1;
                                if (bit_q == 4'd8) begin
                                    state_n = S_DONE;
                                    rerr_n  = 1'b0;
                                    if (cmd_q == C_WRITE) begin
                                        rack_n = asmp_q;
                                    end else begin
                                        rack_n  = ack_q;
                                        rdata_n = shr_q;
                                    end
                                end else begin
                                    bit_n = bit_q + 4'd1;
                                    sda_n = bit_drive(cmd_q, data_q, ack_q,
                                                      bit_q + 4'd1);
                                end
                            end
                        endcase
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.cmd_ready_o = (state_q == S_IDLE);
    assign bus.rsp_valid_o = (state_q == S_DONE);
    assign bus.rsp_data_o  = rdata_q;
    assign bus.rsp_ack_o   = rack_q;
    assign bus.rsp_err_o   = rerr_q;
    assign busy_o          = (state_q != S_IDLE);
    assign scl_oe_o        = scl_q;
    assign sda_oe_o        = sda_q;
endmodule
